im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//   Write-side counterpart of the instruction memory. Accepts a program as a byte
//   stream over a valid/ready handshake and packs it into 32-bit words. Writes each
//   word into the instruction memory write port at consecutive word indices (pc[11:2]).
//   Holds the CPU in reset (cpu_hold) until the whole image is loaded.
// PARAMETERS
//   ADDR_W      10   word-index width; memory depth = 2**ADDR_W words (1024)
//   BIG_ENDIAN  1    1: first byte of a word -> bits [31:24]; 0: first byte -> bits [7:0]
// PORTS
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        pulse: begin a load of len words (sampled only in IDLE)
//   len         in   ADDR_W+1 number of words to load, sampled with start
//   byte_valid  in   1        byte_data valid
//   byte_data   in   8        program byte
//   byte_ready  out  1        loader accepts a byte this cycle
//   im_we       out  1        instruction-memory write enable (one-cycle pulse per word)
//   im_waddr    out  ADDR_W   word index written (equals pc[11:2] of that instruction)
//   im_wdata    out  32       instruction word
//   busy        out  1        load in progress
//   done        out  1        sticky: last load completed; cleared by the next accepted start
//   err         out  1        sticky: start rejected (len==0 or len>2**ADDR_W); cleared by the next start
//   checksum    out  32       XOR of all words written in the current/last load
//   cpu_hold    out  1        1 from reset until done rises; 0 afterwards; 1 again while busy
// BEHAVIOUR
//   Reset (async): state=IDLE; byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, busy=0,
//     done=0, err=0, checksum=0, cpu_hold=1. Byte count and word count = 0.
//     A partial word is discarded. Words already written stay in memory.
//   FSM states: IDLE, LOAD, WRITE, DONE.
//   IDLE:
//     start & len valid -> LOAD. Clear checksum, word index, byte count, done and err.
//     start & len invalid -> stay in IDLE, err=1.
//   LOAD:
//     byte_ready=1. A byte is accepted when byte_valid & byte_ready; it goes into the
//       packing register at the position set by BIG_ENDIAN.
//     When the 4th byte is accepted -> WRITE. Byte count wraps 3 -> 0.
//   WRITE (exactly 1 cycle):
//     byte_ready=0, im_we=1; im_waddr = current index, im_wdata = packed word.
//     checksum ^= word; index += 1.
//     If index+1 == len -> DONE, else -> LOAD.
//   DONE: done=1, busy=0, cpu_hold=0; next cycle -> IDLE.
//   Latency: im_we is asserted in the cycle after the 4th byte handshake.
//     Sustained throughput is 4 bytes per 5 cycles.
//   im_we, im_waddr, im_wdata and checksum are registered. byte_ready is decoded from
//     the state. busy = (state==LOAD || state==WRITE).
//   A start while busy is ignored; it does not restart or corrupt the load.
//   byte_valid outside LOAD is ignored and no byte is consumed.
//   len == 2**ADDR_W: the final index is 2**ADDR_W-1; the index never wraps within a load.
//   im_waddr holds its last value when im_we=0. The memory must gate writes on im_we only.
// STRUCTURE
//   Shared header im_loader_defs.vh holds:
//     state encodings (`LDR_IDLE..`LDR_DONE, 2 bits)
//     `IM_ADDR_W 10, also used by the instruction memory so its depth matches.
//   One sub-module, word_packer: byte shift/insert register plus 2-bit byte counter.
//     Inputs: clk, reset, clr, shift_en, byte, BIG_ENDIAN.
//     Outputs: word[31:0], full (4th byte accepted this cycle).
//   FSM, index counter, checksum and output registers live in im_loader.
// TESTING
//   1. Reset, start len=2; stream 8'h34,3C,01,00,8'h20,08,00,04 (BIG_ENDIAN=1)
//      -> im_we pulses at idx 0 data 32'h343C0100, idx 1 data 32'h20080004;
//      checksum=32'h14340104; done=1; cpu_hold falls with done.
//   2. BIG_ENDIAN=0, one word, bytes 00,01,3C,34 -> im_wdata=32'h343C0100.
//   3. byte_valid toggling randomly (~50%) over len=5 -> the same 5 words in order,
//      no byte dropped or duplicated, byte_ready=0 in every im_we cycle.
//   4. start with len=0, then with len=1025 -> err=1 each time, no im_we, stays IDLE.
//      Next start with len=1 -> err clears.
//   5. Assert reset after 6 of 8 bytes -> all outputs at reset values immediately,
//      cpu_hold=1. A restarted len=1 load writes idx 0 using only new bytes.
//   6. start pulses during LOAD and a 1024-word load -> start ignored,
//      last write at idx 1023, done after exactly 1024 im_we pulses.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it feeds.
package im_loader_pkg;

  // Word-index width; the instruction memory uses the same value so depths match.
  localparam int unsigned IM_ADDR_W = 10;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_LOAD  = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_t;

  // A load length is usable when it is non-zero and fits the memory depth.
  function automatic logic len_ok(input logic [31:0] n, input int unsigned aw);
    return (n != 32'd0) && (n <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/im_loader_word_packer.sv
// Packs a byte stream into 32-bit words; byte order set by BIG_ENDIAN.
module word_packer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,   // 'byte' is a reserved word in SystemVerilog
  output logic [31:0] word,
  output logic        full
);

  logic [23:0] held;
  logic [1:0]  cnt;

  // Word includes the incoming byte so the parent can register it on the 4th handshake.
  always_comb begin
    if (BIG_ENDIAN) word = {held, byte_in};
    else            word = {byte_in, held};
    full = shift_en && (cnt == 2'd3);
  end

  // Byte holding register and position counter; counter wraps 3 -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held <= '0;
      cnt  <= '0;
    end else if (clr) begin
      held <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      cnt <= cnt + 2'd1;
      if (BIG_ENDIAN) held <= word[23:0];
      else            held <= word[31:8];
    end
  end

endmodule

// File: rtl/im_loader.sv
// Loads a program byte stream into instruction memory and holds the CPU until done.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = IM_ADDR_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum,
  output logic              cpu_hold
);

  ldr_state_t      state, state_nxt;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] len_q;
  logic            start_ok, start_bad, accept, full;
  logic [31:0]     word;

  assign start_ok  = (state == LDR_IDLE) && start &&  len_ok(32'(len), ADDR_W);
  assign start_bad = (state == LDR_IDLE) && start && !len_ok(32'(len), ADDR_W);
  assign accept    = byte_valid && byte_ready;

  word_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .shift_en (accept),
    .byte_in  (byte_data),
    .word     (word),
    .full     (full)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LDR_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; idx is already post-incremented while in WRITE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LDR_IDLE:  if (start_ok) state_nxt = LDR_LOAD;
      LDR_LOAD:  if (full)     state_nxt = LDR_WRITE;
      LDR_WRITE: state_nxt = (idx == len_q) ? LDR_DONE : LDR_LOAD;
      LDR_DONE:  state_nxt = LDR_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    byte_ready = (state == LDR_LOAD);
    busy       = (state == LDR_LOAD) || (state == LDR_WRITE);
  end

  // Registered write port, index, checksum and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_we    <= 1'b0;
      im_waddr <= '0;
      im_wdata <= '0;
      idx      <= '0;
      len_q    <= '0;
      checksum <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      im_we <= 1'b0;
      if (start_ok) begin
        idx      <= '0;
        len_q    <= len;
        checksum <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (start_bad) err <= 1'b1;
      if (full) begin
        im_we    <= 1'b1;
        im_waddr <= idx[ADDR_W-1:0];
        im_wdata <= word;
        checksum <= checksum ^ word;
        idx      <= idx + 1'b1;
      end
      if (state == LDR_WRITE && state_nxt == LDR_DONE) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: big- and little-endian instances share one stream.
module tb_im_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;

  logic          byte_ready, im_we, busy, done, err, cpu_hold;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata, checksum;
  logic          byte_ready_l, im_we_l, busy_l, done_l, err_l, cpu_hold_l;
  logic [AW-1:0] im_waddr_l;
  logic [31:0]   im_wdata_l, checksum_l;

  im_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .checksum(checksum), .cpu_hold(cpu_hold)
  );

  im_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_l),
    .im_we(im_we_l), .im_waddr(im_waddr_l), .im_wdata(im_wdata_l),
    .busy(busy_l), .done(done_l), .err(err_l), .checksum(checksum_l), .cpu_hold(cpu_hold_l)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;   // stream order
    logic [31:0] be, le;           // expected packed words
  } wvec_t;

  typedef struct {
    int          first;
    int          n;
    bit          rnd;
    logic [31:0] cks_be, cks_le;
    string       tag;
  } load_t;

  typedef struct {
    logic [AW:0] len;
    logic        err;
  } errvec_t;

  wvec_t       vt [5];
  logic [31:0] bigw [1024];

  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_be[$];
  logic [31:0]   cap_le[$];
  int            we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] vbyte(input wvec_t v, input int i);
    case (i)
      0:       return v.b0;
      1:       return v.b1;
      2:       return v.b2;
      default: return v.b3;
    endcase
  endfunction

  // Capture every write pulse on both instances; no byte may be taken while writing.
  always @(negedge clk) begin
    if (im_we) begin
      cap_addr.push_back(im_waddr);
      cap_be.push_back(im_wdata);
      we_cnt++;
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
    if (im_we_l) cap_le.push_back(im_wdata_l);
  end

  task automatic clear_cap();
    cap_addr.delete();
    cap_be.delete();
    cap_le.delete();
    we_cnt = 0;
  endtask

  task automatic start_load(input logic [AW:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Offer one byte until the handshake happens; optional random idle cycles.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  n   = 0;
    bit  acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 1) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        acc        = byte_ready;
      end
      n++;
      if (!acc && n > 100) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte_timeout: got no handshake expected one within 100 cycles");
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_im_waddr"}, 32'(im_waddr), 32'd0);
    check({tag, "_im_wdata"}, im_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_le_checksum"}, checksum_l, 32'd0);
    check({tag, "_le_cpu_hold"}, 32'(cpu_hold_l), 32'd1);
  endtask

  task automatic run_load(input load_t ld);
    clear_cap();
    start_load(11'(ld.n));
    check({ld.tag, "_busy"}, 32'(busy), 32'd1);
    check({ld.tag, "_hold_while_busy"}, 32'(cpu_hold), 32'd1);
    check({ld.tag, "_done_cleared"}, 32'(done), 32'd0);
    check({ld.tag, "_err_cleared"}, 32'(err), 32'd0);
    for (int w = 0; w < ld.n; w++) begin
      for (int b = 0; b < 4; b++) send_byte(vbyte(vt[ld.first + w], b), ld.rnd);
      if (!ld.rnd) begin
        @(negedge clk);
        check({ld.tag, "_we_latency"}, 32'(im_we), 32'd1);
      end
    end
    bus_idle();
    wait_done(ld.tag, 20);
    check({ld.tag, "_n_writes"}, 32'(cap_be.size()), 32'(ld.n));
    check({ld.tag, "_n_writes_le"}, 32'(cap_le.size()), 32'(ld.n));
    for (int w = 0; w < ld.n && w < cap_be.size() && w < cap_le.size(); w++) begin
      check({ld.tag, "_addr"}, 32'(cap_addr[w]), 32'(w));
      check({ld.tag, "_data_be"}, cap_be[w], vt[ld.first + w].be);
      check({ld.tag, "_data_le"}, cap_le[w], vt[ld.first + w].le);
    end
    check({ld.tag, "_checksum"}, checksum, ld.cks_be);
    check({ld.tag, "_checksum_le"}, checksum_l, ld.cks_le);
  endtask

  task automatic pulse_start_busy();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    len        = 11'd1;
    @(negedge clk);
    start      = 1'b0;
    len        = 11'd1024;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_t       loads [4];
    errvec_t     evs [3];
    logic [31:0] cks;
    int          bad;

    vt[0] = '{8'h34, 8'h3C, 8'h01, 8'h00, 32'h343C0100, 32'h00013C34};
    vt[1] = '{8'h20, 8'h08, 8'h00, 8'h04, 32'h20080004, 32'h04000820};
    vt[2] = '{8'h00, 8'h01, 8'h3C, 8'h34, 32'h00013C34, 32'h343C0100};
    vt[3] = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 32'hFF00A55A, 32'h5AA500FF};
    vt[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678, 32'h78563412};

    loads[0] = '{0, 2, 1'b0, 32'h14340104, 32'h04013414, "two_words"};
    loads[1] = '{2, 1, 1'b0, 32'h00013C34, 32'h343C0100, "one_word"};
    loads[2] = '{0, 5, 1'b1, 32'hF901CE12, 32'h12CE01F9, "gappy_five"};
    loads[3] = '{4, 1, 1'b0, 32'h12345678, 32'h78563412, "after_reset"};

    evs[0] = '{11'd0,    1'b1};
    evs[1] = '{11'd1025, 1'b1};
    evs[2] = '{11'd2047, 1'b1};

    #2 reset = 1'b1;
    #2 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_hold_before_load", 32'(cpu_hold), 32'd1);

    run_load(loads[0]);

    // Rejected lengths: flag only, no state change, earlier done stays set.
    foreach (evs[i]) begin
      clear_cap();
      start_load(evs[i].len);
      repeat (3) @(negedge clk);
      check("bad_len_err", 32'(err), 32'(evs[i].err));
      check("bad_len_busy", 32'(busy), 32'd0);
      check("bad_len_no_write", 32'(we_cnt), 32'd0);
      check("bad_len_done_kept", 32'(done), 32'd1);
    end

    run_load(loads[1]);
    run_load(loads[2]);

    // Reset after 6 of 8 bytes: outputs return to reset values at once.
    clear_cap();
    start_load(11'd2);
    for (int b = 0; b < 6; b++) send_byte(vbyte(vt[b / 4], b % 4), 1'b0);
    @(posedge clk);
    #2;
    byte_valid = 1'b0;
    reset      = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_hold", 32'(cpu_hold), 32'd1);
    run_load(loads[3]);

    // Full-depth load with start pulses while busy.
    clear_cap();
    cks = '0;
    for (int k = 0; k < 1024; k++) begin
      bigw[k] = (32'(k) * 32'h9E3779B1) ^ 32'hC0DE0000;
      cks     = cks ^ bigw[k];
    end
    start_load(11'd1024);
    check("big_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 1024; k++) begin
      if (k == 3) pulse_start_busy();
      for (int b = 0; b < 4; b++) begin
        if (k == 7 && b == 2) pulse_start_busy();
        send_byte(bigw[k][31 - 8 * b -: 8], 1'b0);
      end
    end
    bus_idle();
    wait_done("big", 20);
    check("big_writes_at_done", 32'(we_cnt), 32'd1024);
    check("big_last_addr", (cap_addr.size() > 0) ? 32'(cap_addr[cap_addr.size() - 1]) : 32'hFFFF_FFFF,
          32'd1023);
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k >= cap_be.size() || k >= cap_le.size()) bad++;
      else if (cap_addr[k] !== AW'(k) || cap_be[k] !== bigw[k] || cap_le[k] !== bswap(bigw[k])) bad++;
    end
    check("big_word_errors", 32'(bad), 32'd0);
    check("big_checksum", checksum, cks);
    check("big_checksum_le", checksum_l, bswap(cks));
    repeat (4) @(negedge clk);
    check("big_no_extra_writes", 32'(we_cnt), 32'd1024);
    check("big_idle_busy", 32'(busy), 32'd0);
    check("big_done_sticky", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
